instr_mem_loader: RTL
=====================

// Module: instr_mem_loader
// PURPOSE
// Boot-time loader upstream of the instruction memory feeding the single-cycle datapath.
// Receives a byte stream over a valid/ready handshake and assembles big-endian 32-bit words.
// Writes the words into instruction memory from BASE_ADDR upward, holding the datapath in
// reset until the image is complete. It then releases the core, whose PC starts at word 0.
// PARAMETERS
// ADDR_W     8    word-address width of instruction memory
// DEPTH      256  instruction memory capacity in words (<= 2**ADDR_W)
// BASE_ADDR  0    word address of first loaded instruction
// PORTS
// clk         in   1       system clock, rising edge
// reset       in   1       asynchronous, active-high
// in_valid    in   1       in_data holds a byte
// in_data     in   8       stream byte
// in_ready    out  1       loader accepts a byte this cycle
// mem_we      out  1       instruction-memory write strobe, one cycle per word
// mem_addr    out  ADDR_W  word address for mem_wdata
// mem_wdata   out  32      assembled instruction word
// core_reset  out  1       reset to datapath; high until load completes
// done        out  1       image loaded successfully (sticky)
// error       out  1       load aborted (sticky)
// BEHAVIOUR
// - Reset (async, any state): state=S_LEN, byte_cnt=0, word_cnt=0, len=0. Outputs:
//   in_ready=1, mem_we=0, mem_addr=0, mem_wdata=0, core_reset=1, done=0, error=0.
// - Byte is accepted only on in_valid&&in_ready. Bytes shift into a 32-bit assembly reg,
//   first byte -> bits[31:24]. byte_cnt (2b) wraps 3->0 on each 4th byte.
// - FSM states: S_LEN, S_LOAD, S_CHK (macro only), S_DONE, S_ERR.
//   S_LEN: 4 bytes form len (word count).
//     len==0 -> S_DONE. len>DEPTH -> S_ERR. Otherwise -> S_LOAD.
//   S_LOAD: each completed word registers mem_we=1, mem_addr=BASE_ADDR+word_cnt, and
//     mem_wdata=word on the next cycle. word_cnt++. After word len: -> S_DONE
//     (or S_CHK with macro).
//   S_DONE: in_ready=0; done=1; core_reset=0 from the cycle after the last mem_we pulse.
//   S_ERR: in_ready=0; error=1; core_reset stays 1; leave only via reset.
// - Latency: mem_we is asserted exactly 1 cycle after the handshake of the word's 4th byte.
//   mem_we is high for one cycle only; mem_addr and mem_wdata hold between writes.
// - Back-to-back bytes (in_valid held high) are sustained at 1 byte/cycle; no stall is needed.
// - in_valid gaps are allowed anywhere; partial words are held indefinitely.
// - Bytes presented in S_DONE/S_ERR are ignored (in_ready=0).
// - Address arithmetic: BASE_ADDR+word_cnt is truncated to ADDR_W.
//   len <= DEPTH bounds word_cnt; BASE_ADDR+len > 2**ADDR_W wraps silently.
// - Reset mid-load: all progress is discarded, core_reset=1 immediately, and the stream restarts at S_LEN.
// CONFIGURATION
// LOADER_CHECKSUM_EN defined:
//   - The stream carries an extra 4-byte word after the last instruction, consumed in S_CHK.
//   - This word is not written to memory.
//   - Check value: sum of the len header and all instruction words, mod 2**32.
//   - Match -> S_DONE. Mismatch -> S_ERR.
//   - core_reset releases only after the checksum matches.
//   - With len==0 the checksum word (value 0) is still required.
// LOADER_CHECKSUM_EN undefined:
//   - S_CHK and the accumulator are absent.
//   - S_LOAD goes directly to S_DONE after word len.
// TESTING
// 1. len=2, words 0x20080005, 0x01095020, streamed back-to-back:
//    - mem_we pulses at addr 0 then 1, with exactly those values.
//    - core_reset falls and done=1 the cycle after the 2nd pulse.
// 2. len=0 -> no mem_we; done=1; core_reset=0; in_ready=0 afterwards.
// 3. len=DEPTH+1 -> error=1, in_ready=0, core_reset stays 1, no writes.
// 4. len=1 with 3-cycle in_valid gaps between bytes -> single write 1 cycle after the 4th byte.
// 5. Reset asserted after 2 of 4 bytes of word 1 -> outputs return to reset values
//    at once; a fresh len=1 stream writes addr 0.
// 6. (LOADER_CHECKSUM_EN) len=1, word 0x00000010, checksum 0x00000011 -> done=1.
//    Same stream with checksum 0x00000012 -> error=1, core_reset=1.

Source files
------------

// File: rtl/instr_mem_loader.sv
// rtl/instr_mem_loader.sv - boot-time byte-stream loader for instruction memory
//
// Assembles big-endian 32-bit words from a byte stream and writes them into
// instruction memory from BASE_ADDR upward. The datapath is held in reset
// until the whole image has been written.
// Stream format: 4-byte word count (len), then len instruction words, then
// (LOADER_CHECKSUM_EN only) a 4-byte checksum word.
//
// Optional feature macro: LOADER_CHECKSUM_EN
//   The checksum is len + all instruction words, mod 2**32. It is not written
//   to memory. A mismatch aborts the load.
//
// Ports:
//   clk        in   1       system clock, rising edge
//   reset      in   1       asynchronous, active-high
//   in_valid   in   1       in_data holds a byte
//   in_data    in   8       stream byte
//   in_ready   out  1       loader accepts a byte this cycle
//   mem_we     out  1       instruction-memory write strobe, one cycle per word
//   mem_addr   out  ADDR_W  word address for mem_wdata
//   mem_wdata  out  32      assembled instruction word
//   core_reset out  1       datapath reset, high until the load completes
//   done       out  1       image loaded successfully (sticky)
//   error      out  1       load aborted (sticky until reset)

module instr_mem_loader #(
    parameter int ADDR_W    = 8,
    parameter int DEPTH     = 256,
    parameter int BASE_ADDR = 0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              core_reset,
    output logic              done,
    output logic              error
);

    typedef enum logic [2:0] {
        S_LEN  = 3'd0,
        S_LOAD = 3'd1,
        S_DONE = 3'd2,
        S_ERR  = 3'd3
`ifdef LOADER_CHECKSUM_EN
        ,
        S_CHK  = 3'd4
`endif
    } state_t;

    state_t state_q;
    state_t state_d;

    // Only the three most recent bytes need storing; the fourth byte of a
    // word arrives on in_data and completes it combinationally.
    logic [23:0] asm_q;
    logic [1:0]  byte_cnt_q;
    logic [31:0] len_q;
    logic [31:0] word_cnt_q;

`ifdef LOADER_CHECKSUM_EN
    logic [31:0] acc_q;
`endif

    logic        accept;
    logic        word_done;
    logic [31:0] word_next;
    logic        last_word;

    assign accept    = in_valid && in_ready;
    assign word_next = {asm_q, in_data};
    assign word_done = accept && (byte_cnt_q == 2'd3);
    assign last_word = (word_cnt_q + 32'd1) == len_q;

    // ------------------------------------------------------------------
    // State register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_LEN;
        end else begin
            state_q <= state_d;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic and handshake
    // ------------------------------------------------------------------
    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            S_LEN: begin
                in_ready = 1'b1;
                if (word_done) begin
                    if (word_next == 32'd0) begin
`ifdef LOADER_CHECKSUM_EN
                        // An empty image still carries its (zero) checksum.
                        state_d = S_CHK;
`else
                        state_d = S_DONE;
`endif
                    end else if (word_next > 32'(DEPTH)) begin
                        state_d = S_ERR;
                    end else begin
                        state_d = S_LOAD;
                    end
                end
            end
            S_LOAD: begin
                in_ready = 1'b1;
                if (word_done && last_word) begin
`ifdef LOADER_CHECKSUM_EN
                    state_d = S_CHK;
`else
                    state_d = S_DONE;
`endif
                end
            end
`ifdef LOADER_CHECKSUM_EN
            S_CHK: begin
                in_ready = 1'b1;
                if (word_done) begin
                    state_d = (word_next == acc_q) ? S_DONE : S_ERR;
                end
            end
`endif
            S_DONE: begin
                in_ready = 1'b0;
            end
            S_ERR: begin
                in_ready = 1'b0;
            end
            default: begin
                state_d = S_ERR;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Byte assembly, header capture and memory write port
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            asm_q      <= '0;
            byte_cnt_q <= '0;
            len_q      <= '0;
            word_cnt_q <= '0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
        end else begin
            mem_we <= 1'b0;
            if (accept) begin
                asm_q      <= {asm_q[15:0], in_data};
                byte_cnt_q <= byte_cnt_q + 2'd1;
            end
            if (word_done && state_q == S_LEN) begin
                len_q <= word_next;
            end
            if (word_done && state_q == S_LOAD) begin
                // Address wraps silently at 2**ADDR_W.
                mem_we     <= 1'b1;
                mem_addr   <= ADDR_W'(BASE_ADDR) + word_cnt_q[ADDR_W-1:0];
                mem_wdata  <= word_next;
                word_cnt_q <= word_cnt_q + 32'd1;
            end
        end
    end

`ifdef LOADER_CHECKSUM_EN
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            acc_q <= '0;
        end else if (word_done) begin
            if (state_q == S_LEN) begin
                acc_q <= word_next;
            end else if (state_q == S_LOAD) begin
                acc_q <= acc_q + word_next;
            end
        end
    end
`endif

    // ------------------------------------------------------------------
    // Status outputs. Registered off the state so that core_reset drops
    // the cycle after the final mem_we pulse rather than alongside it.
    // ------------------------------------------------------------------
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            core_reset <= 1'b1;
            done       <= 1'b0;
            error      <= 1'b0;
        end else begin
            core_reset <= (state_q != S_DONE);
            done       <= (state_q == S_DONE);
            error      <= (state_q == S_ERR);
        end
    end

endmodule
